// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared constants and types for the router synchronizer block.
//               NUM_PORTS destination FIFOs, ADDR_W-bit header address,
//               TIMEOUT unread cycles before a FIFO flush.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;
    localparam int TIMEOUT   = 30;

    // Counter width for the per-port timeout (counts 0 .. TIMEOUT-1).
    localparam int CNT_W = $clog2(TIMEOUT);

    // Header address that does not map to any FIFO with three ports.
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef logic [NUM_PORTS-1:0] port_vec_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_sync_timer.sv
`default_nettype none
// ============================================================================
// Module      : router_sync_timer
// Description : One destination port's read timeout. While data is available
//               and not being read, counts sampled edges; on the TIMEOUT-th
//               consecutive such edge a one-cycle soft_reset pulse is issued
//               and counting restarts from zero.
// Ports       : clk        - system clock
//               resetn     - synchronous active-low reset
//               valid_out  - port has data available for the destination
//               read_enb   - destination is reading this cycle
//               soft_reset - registered one-cycle FIFO flush pulse
// Revision    : 1.0 - initial release
// ============================================================================
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic valid_out,
    input  logic read_enb,
    output logic soft_reset
);

    localparam int                  C_CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_soft_reset;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (!valid_out || read_enb) begin
            // Nothing pending or the destination is draining: restart.
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (r_cnt == C_LAST) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b1;
        end else begin
            r_cnt        <= r_cnt + C_ONE;
            r_soft_reset <= 1'b0;
        end
    end

    assign soft_reset = r_soft_reset;

endmodule : router_sync_timer
`default_nettype wire

// File: rtl/router_sync.sv
`default_nettype none
// ============================================================================
// Module      : router_sync
// Description : Glue between the router FSM, the destination FIFOs and the
//               destination read interfaces. Latches the header address,
//               steers the FSM write strobe to the addressed FIFO, reports
//               that FIFO's full flag, derives valid_out from FIFO empty flags
//               and runs a per-port read timeout that flushes stale FIFOs.
// Ports       : clk           - system clock
//               resetn        - synchronous active-low reset
//               detect_add    - header present on data_in, latch address
//               data_in       - header address field
//               write_enb_reg - FSM request to write current byte
//               full          - per-FIFO full flags
//               empty         - per-FIFO empty flags
//               read_enb      - per-port destination read enables
//               write_enb     - one-hot FIFO write enables
//               fifo_full     - full flag of the addressed FIFO
//               valid_out     - per-port data-available flags
//               soft_reset    - per-FIFO one-cycle flush pulses
// Revision    : 1.0 - initial release
// ============================================================================
module router_sync
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  port_vec_t         full,
    input  port_vec_t         empty,
    input  port_vec_t         read_enb,
    output port_vec_t         write_enb,
    output logic              fifo_full,
    output port_vec_t         valid_out,
    output port_vec_t         soft_reset
);

    // One extra bit so NUM_PORTS itself is representable in the compare.
    localparam logic [ADDR_W:0] C_NUM_PORTS = (ADDR_W + 1)'(NUM_PORTS);

    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_vld;
    port_vec_t         w_write_enb;
    logic              w_fifo_full;
    port_vec_t         w_valid_out;

    // ------------------------------------------------------------------
    // Address latch. The write path always uses the previously latched
    // address, so a header and a write in the same cycle go to the old port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
        end else if (detect_add) begin
            r_addr     <= data_in;
            r_addr_vld <= ({1'b0, data_in} < C_NUM_PORTS);
        end
    end

    // ------------------------------------------------------------------
    // Write steering and full reporting. An unroutable address leaves all
    // enables low and reports not-full so the FSM can drop the packet.
    // ------------------------------------------------------------------
    always_comb begin
        w_write_enb = '0;
        w_fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_addr_vld && (r_addr == ADDR_W'(i))) begin
                w_write_enb[i] = write_enb_reg;
                w_fifo_full    = full[i];
            end
        end
    end

    assign w_valid_out = ~empty;

    assign write_enb = w_write_enb;
    assign fifo_full = w_fifo_full;
    assign valid_out = w_valid_out;

    // ------------------------------------------------------------------
    // Independent per-port read timeouts.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_timer
            router_sync_timer #(
                .TIMEOUT_CYC (TIMEOUT)
            ) u_timer (
                .clk        (clk),
                .resetn     (resetn),
                .valid_out  (w_valid_out[g]),
                .read_enb   (read_enb[g]),
                .soft_reset (soft_reset[g])
            );
        end
    endgenerate

endmodule : router_sync
`default_nettype wire

// File: tb/tb_router_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_sync
// Description : Directed self-checking bench for router_sync: address
//               steering, invalid address, same-cycle header/write, timeout
//               firing, timeout avoidance, reset mid-count, multi-port pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_sync;
    import router_pkg::*;

    logic              clk;
    logic              resetn;
    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    port_vec_t         full;
    port_vec_t         empty;
    port_vec_t         read_enb;
    port_vec_t         write_enb;
    logic              fifo_full;
    port_vec_t         valid_out;
    port_vec_t         soft_reset;

    int tests_run = 0;
    int tests_failed = 0;

    router_sync dut (
        .clk           (clk),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .full          (full),
        .empty         (empty),
        .read_enb      (read_enb),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .valid_out     (valid_out),
        .soft_reset    (soft_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        detect_add    = 1'b0;
        data_in       = '0;
        write_enb_reg = 1'b0;
        full          = '0;
        empty         = 3'b111;
        read_enb      = '0;

        // ---------------- reset ----------------
        tick();
        chk("rst_write_enb", 32'(write_enb), 32'h0);
        chk("rst_fifo_full", 32'(fifo_full), 32'h0);
        chk("rst_soft_reset", 32'(soft_reset), 32'h0);
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        write_enb_reg = 1'b1;
        full = 3'b111;
        #1;
        chk("rst_no_addr_write", 32'(write_enb), 32'h0);
        chk("rst_no_addr_full", 32'(fifo_full), 32'h0);
        write_enb_reg = 1'b0;
        full = '0;
        resetn = 1'b1;

        // ---------------- address steering to port 1 ----------------
        detect_add = 1'b1;
        data_in    = 2'b01;
        tick();
        detect_add = 1'b0;
        data_in    = 2'b00;
        #1;
        chk("steer_idle", 32'(write_enb), 32'h0);
        for (int k = 0; k < 4; k++) begin
            write_enb_reg = 1'b1;
            #1;
            chk("steer_we_p1", 32'(write_enb), 32'h2);
            tick();
        end
        write_enb_reg = 1'b0;
        #1;
        chk("steer_after", 32'(write_enb), 32'h0);
        full = 3'b101;
        #1;
        chk("steer_full_other", 32'(fifo_full), 32'h0);
        full = 3'b010;
        #1;
        chk("steer_full_p1", 32'(fifo_full), 32'h1);
        full = '0;

        // ---------------- invalid address ----------------
        detect_add = 1'b1;
        data_in    = INVALID_ADDR;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("inv_write_enb", 32'(write_enb), 32'h0);
            chk("inv_fifo_full", 32'(fifo_full), 32'h0);
            tick();
        end
        write_enb_reg = 1'b0;
        full = '0;

        // ---------------- same-cycle header and write ----------------
        detect_add = 1'b1;
        data_in    = 2'b00;
        tick();
        data_in       = 2'b10;
        write_enb_reg = 1'b1;
        #1;
        chk("same_cycle_old", 32'(write_enb), 32'h1);
        tick();
        detect_add = 1'b0;
        full = 3'b100;
        #1;
        chk("same_cycle_new", 32'(write_enb), 32'h4);
        chk("same_cycle_full", 32'(fifo_full), 32'h1);
        write_enb_reg = 1'b0;
        full = '0;
        tick();

        // ---------------- timeout fires on port 0, twice ----------------
        empty    = 3'b110;
        read_enb = '0;
        #1;
        chk("to0_valid_out", 32'(valid_out), 32'h1);
        for (int k = 1; k <= 60; k++) begin
            tick();
            chk($sformatf("to0_edge%0d", k), 32'(soft_reset),
                ((k == 30) || (k == 60)) ? 32'h1 : 32'h0);
        end
        empty = 3'b111;
        tick();
        chk("to0_cleared", 32'(soft_reset), 32'h0);

        // ---------------- timeout avoided by a read on port 2 ----------------
        empty = 3'b011;
        for (int k = 1; k <= 62; k++) begin
            read_enb = (k == 29) ? 3'b100 : 3'b000;
            tick();
            chk($sformatf("to2_edge%0d", k), 32'(soft_reset),
                (k == 59) ? 32'h4 : 32'h0);
        end
        read_enb = '0;
        empty = 3'b111;
        tick();

        // ---------------- reset mid-count on port 1 ----------------
        empty = 3'b101;
        for (int k = 1; k <= 20; k++) begin
            tick();
        end
        chk("to1_pre_rst", 32'(soft_reset), 32'h0);
        resetn = 1'b0;
        tick();
        chk("to1_in_rst", 32'(soft_reset), 32'h0);
        resetn = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            chk($sformatf("to1_edge%0d", k), 32'(soft_reset),
                (k == 30) ? 32'h2 : 32'h0);
        end
        empty = 3'b111;
        tick();

        // ---------------- simultaneous timeouts ----------------
        empty = 3'b000;
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (k >= 29) begin
                chk($sformatf("all_edge%0d", k), 32'(soft_reset),
                    (k == 30) ? 32'h7 : 32'h0);
            end
        end
        empty = 3'b111;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_router_sync
`default_nettype wire
